// File: rtl/data_ram_resp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | data_ram_resp_pkg: shared widths, store-buffer entry, byte merge |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package data_ram_resp_pkg;

  localparam int WORD_W    = 32;
  localparam int SEL_W     = 4;
  localparam int MAX_IDX_W = 30;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic [WORD_W-1:0]    data;
    logic [SEL_W-1:0]     sel;
  } sb_entry_t;

  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] base,
    input logic [WORD_W-1:0] data,
    input logic [SEL_W-1:0]  sel
  );
    logic [WORD_W-1:0] w;
    w = base;
    for (int n = 0; n < SEL_W; n++) begin
      if (sel[n]) w[8*n +: 8] = data[8*n +: 8];
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_store_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dram_store_buf: circular store FIFO with per-lane forwarding    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module dram_store_buf
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  sb_entry_t            push_entry_i,
  input  logic                 pop_i,
  input  logic [MAX_IDX_W-1:0] lookup_idx_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output sb_entry_t            head_o,
  output logic [WORD_W-1:0]    fwd_data_o,
  output logic [SEL_W-1:0]     fwd_valid_o
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t          entries_q [DEPTH];
  sb_entry_t          entries_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   slot;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push_i) begin
      entries_d[tail_q] = push_entry_i;
      tail_d            = tail_q + PTR_W'(1);
      count_d           = count_d + CNT_W'(1);
    end
    if (pop_i) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_d - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Walk oldest to youngest so the youngest matching entry owns each lane.
  always_comb begin
    fwd_data_o  = '0;
    fwd_valid_o = '0;
    slot        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (entries_q[slot].idx == lookup_idx_i)) begin
        fwd_data_o  = byte_merge(fwd_data_o, entries_q[slot].data, entries_q[slot].sel);
        fwd_valid_o = fwd_valid_o | entries_q[slot].sel;
      end
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = entries_q[head_q];

endmodule
`default_nettype wire

// File: rtl/data_ram_resp.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | data_ram_resp: MEM-stage data RAM responder, same-cycle reads   |
// | Option macro DATA_RAM_SB_EN enables the posted store buffer.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stallreq_o,
  output logic [CNT_W-1:0]  sb_count_o,
  output logic              sb_empty_o
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] req_idx;
  logic              rd_req;
  logic              wr_req;
  logic [WORD_W-1:0] rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [WORD_W-1:0] mem_wdata;

  assign req_idx = addr_i[ADDR_W+1:2];
  assign rd_req  = ce_i & ~we_i;
  assign wr_req  = ce_i & we_i & (|sel_i);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

`ifdef DATA_RAM_SB_EN
  sb_entry_t         push_entry;
  sb_entry_t         head_entry;
  logic [WORD_W-1:0] fwd_data;
  logic [SEL_W-1:0]  fwd_valid;
  logic              sb_full;
  logic              sb_empty;
  logic              push;
  logic              pop;
  logic              unused_ok;

  always_comb begin
    push_entry.idx  = MAX_IDX_W'(req_idx);
    push_entry.data = data_i;
    push_entry.sel  = sel_i;
  end

  assign stallreq_o = wr_req & sb_full;
  assign push       = wr_req & ~sb_full;
  // Drain only when the port is idle or a stalled write frees a slot; never during reset.
  assign pop        = rst & (~ce_i | stallreq_o) & ~sb_empty;

  dram_store_buf #(
    .DEPTH (SB_DEPTH),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .lookup_idx_i (MAX_IDX_W'(req_idx)),
    .count_o      (sb_count_o),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .head_o       (head_entry),
    .fwd_data_o   (fwd_data),
    .fwd_valid_o  (fwd_valid)
  );

  assign mem_we     = pop;
  assign mem_widx   = head_entry.idx[ADDR_W-1:0];
  assign mem_wdata  = byte_merge(mem[mem_widx], head_entry.data, head_entry.sel);
  assign rd_word    = byte_merge(mem[req_idx], fwd_data, fwd_valid);
  assign sb_empty_o = sb_empty;
  assign unused_ok  = ^{addr_i[31:ADDR_W+2], addr_i[1:0], head_entry.idx[MAX_IDX_W-1:ADDR_W]};
`else
  logic unused_ok;

  assign mem_we     = wr_req;
  assign mem_widx   = req_idx;
  assign mem_wdata  = byte_merge(mem[req_idx], data_i, sel_i);
  assign rd_word    = mem[req_idx];
  assign stallreq_o = 1'b0;
  assign sb_count_o = '0;
  assign sb_empty_o = 1'b1;
  assign unused_ok  = ^{addr_i[31:ADDR_W+2], addr_i[1:0], rst};
`endif

  assign data_o = rd_req ? rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// Directed bench for data_ram_resp with a model-memory scoreboard for reads.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stallreq_o;
  logic [2:0]  sb_count_o;
  logic        sb_empty_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  data_ram_resp #(.ADDR_W(17), .SB_DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .sel_i      (sel_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .stallreq_o (stallreq_o),
    .sb_count_o (sb_count_o),
    .sb_empty_o (sb_empty_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] b, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = b;
    for (int n = 0; n < 4; n++) if (s[n]) w[8*n +: 8] = d[8*n +: 8];
    return w;
  endfunction

  function automatic int key(input logic [31:0] a);
    return int'(a[18:2]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(key(a))) return model[key(a)];
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce_i = 1'b0; we_i = 1'b0; sel_i = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents a write until accepted (bounded), updating the architectural model.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int tries;
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
    tries = 0;
    #1;
`ifndef DATA_RAM_SB_EN
    chk("no_stall", {31'b0, stallreq_o}, 32'd0);
`endif
    while (stallreq_o && tries < 3) begin
      tick();
      tries++;
    end
    if (stallreq_o) chk("stall_bound", {31'b0, stallreq_o}, 32'd0);
    if (s != 4'b0) model[key(a)] = merge(model_rd(a), d, s);
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
    exp_q.push_back(model_rd(a));
    #1;
    chk(tag, data_o, exp_q.pop_front());
    tick();
  endtask

  logic [31:0] save0, save4;

  initial begin
    #1;
    // Reset with the port idle
    rst = 1'b0;
    idle(2);
    chk("rst_count", 32'(sb_count_o), 32'd0);
    chk("rst_empty", {31'b0, sb_empty_o}, 32'd1);
    chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b1;
    tick();

`ifdef DATA_RAM_SB_EN
    // Forwarding from the buffer, then from the array after drain
    wr(32'h100, 32'h11223344, 4'hF);
    chk("fwd_count1", 32'(sb_count_o), 32'd1);
    rd("fwd_read", 32'h100);
    idle(1);
    chk("drain_count0", 32'(sb_count_o), 32'd0);
    rd("array_read", 32'h100);

    // Byte merge across multiple buffered entries
    wr(32'h100, 32'h0000AA00, 4'b0010);
    wr(32'h100, 32'hBB000000, 4'b1000);
    rd("merge_read", 32'h100);
    wr(32'h100, 32'h000000CC, 4'b0001);
    wr(32'h100, 32'h000000DD, 4'b0001);
    rd("youngest_wins", 32'h100);
    idle(4);
    chk("merge_drained", 32'(sb_count_o), 32'd0);
    rd("merge_committed", 32'h100);

    // Full buffer stalls a single cycle
    wr(32'h0, 32'hA0A0A0A0, 4'hF);
    wr(32'h4, 32'hB1B1B1B1, 4'hF);
    wr(32'h8, 32'hC2C2C2C2, 4'hF);
    wr(32'hC, 32'hD3D3D3D3, 4'hF);
    chk("full_count", 32'(sb_count_o), 32'd4);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; data_i = 32'hE4E4E4E4; sel_i = 4'hF;
    #1;
    chk("stall_on", {31'b0, stallreq_o}, 32'd1);
    tick();
    chk("stall_off", {31'b0, stallreq_o}, 32'd0);
    chk("stall_count3", 32'(sb_count_o), 32'd3);
    model[key(32'h10)] = 32'hE4E4E4E4;
    tick();
    chk("refill_count4", 32'(sb_count_o), 32'd4);
    idle(4);
    chk("full_drained", 32'(sb_count_o), 32'd0);
    chk("full_empty", {31'b0, sb_empty_o}, 32'd1);
    for (int i = 0; i < 5; i++) rd("full_read", 32'(i * 4));

    // Reset discards buffered writes
    save0 = model_rd(32'h0);
    save4 = model_rd(32'h4);
    wr(32'h0, 32'hDEAD0000, 4'hF);
    wr(32'h4, 32'h0000BEEF, 4'b0011);
    chk("pre_rst_count", 32'(sb_count_o), 32'd2);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("mid_rst_count", 32'(sb_count_o), 32'd0);
    model[key(32'h0)] = save0;
    model[key(32'h4)] = save4;
    idle(2);
    rd("rst_orig0", 32'h0);
    rd("rst_orig4", 32'h4);
`else
    // Direct commit to the array
    wr(32'h20, 32'hCAFEF00D, 4'hF);
    rd("direct_read", 32'h20);
    wr(32'h100, 32'h11223344, 4'hF);
    wr(32'h100, 32'h0000AA00, 4'b0010);
    wr(32'h100, 32'hBB000000, 4'b1000);
    rd("merge_read", 32'h100);
    wr(32'h100, 32'h000000CC, 4'b0001);
    wr(32'h100, 32'h000000DD, 4'b0001);
    rd("youngest_wins", 32'h100);
    wr(32'h100, 32'hFFFFFFFF, 4'b0000);
    rd("sel0_noop", 32'h100);

    // Back-to-back writes never stall
    for (int i = 0; i < 8; i++) wr(32'(i * 4 + 32'h200), 32'h5A000000 + 32'(i * 32'h01010101), 4'hF);
    chk("direct_count", 32'(sb_count_o), 32'd0);
    chk("direct_empty", {31'b0, sb_empty_o}, 32'd1);
    for (int i = 0; i < 8; i++) rd("b2b_read", 32'(i * 4 + 32'h200));
    // Byte offset bits are ignored
    rd("addr_lsb", 32'h203);
`endif

    idle(1);
    chk("idle_data", data_o, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
Data-memory responder for the CPU core's MEM-stage RAM interface: it serves ce/we/sel/addr/data requests and returns read data in the same cycle. Writes are posted into a small store buffer and committed to the word array on idle cycles. Reads merge buffered bytes over array bytes. stallreq_o feeds ctrl as an additional stall source when the buffer is full.

Parameters:
ADDR_W, 17, word-index bits; array holds 2^ADDR_W 32-bit words
SB_DEPTH, 4, store-buffer entries (power of two, >=2)
CNT_W, 3, width of sb_count_o (must hold SB_DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset
ce_i  in  1  access enable
we_i  in  1  1=write, 0=read (valid when ce_i=1)
addr_i  in  32  byte address; bits [ADDR_W+1:2] index the word, bits [1:0] ignored
sel_i  in  4  byte-lane enables, bit n = data bits [8n+7:8n]
data_i  in  32  write data
data_o  out  32  read data, combinational
stallreq_o  out  1  write refused, buffer full; combinational
sb_count_o  out  CNT_W  entries currently buffered
sb_empty_o  out  1  sb_count_o==0

Behaviour:
- Reset (rst=0 at posedge): buffer emptied, pending writes discarded, head/tail pointers=0. Array contents are not reset. After reset: sb_count_o=0, sb_empty_o=1, stallreq_o=0. data_o=0 while ce_i=0.
- Read (ce_i=1, we_i=0): data_o is valid in the same cycle. Per byte lane, start with the array word, then overlay each valid buffer entry with a matching word index and that lane's sel bit set, applied oldest to youngest so the youngest wins. sel_i does not mask reads; the full word is returned.
- Write (ce_i=1, we_i=1, sel_i!=0): if not full, enqueue {word index, data_i, sel_i} at the tail on posedge and set stallreq_o=0. If full, stallreq_o=1 and nothing is enqueued; the core holds the request and re-presents it.
- Write with sel_i=0: no-op, never stalls.
- ce_i=0: data_o=0, stallreq_o=0.
- Drain: on a posedge where (ce_i=0 or stallreq_o=1) and the buffer is non-empty, the head entry is committed to the array (only its sel lanes) and popped. Drains are limited to one per cycle.
- A stalled write drains one entry, so the stall lasts exactly 1 cycle and the write enqueues on the next cycle.
- Simultaneous enqueue and drain cannot occur, because enqueue requires ce_i=1 and no stall.
- Pointers wrap modulo SB_DEPTH; full is count==SB_DEPTH.
- Reset asserted mid-operation discards the buffer regardless of in-flight requests.

Optional Feature:
DATA_RAM_SB_EN.
- Defined: store buffer as above.
- Undefined: writes commit directly to the array on posedge (sel lanes only); reads return the array word only; stallreq_o tied 0, sb_count_o tied 0, sb_empty_o tied 1. Same-cycle read-after-write is impossible, so data_o timing is identical.

Decomposition:
- Shared defines package: word/sel widths, SB entry layout (word index, data, sel), and the byte-merge function (array word, entry data, sel -> word).
- One sub-module, dram_store_buf: circular FIFO with count, full/empty, head-entry output, and parallel address-compare forwarding producing per-lane override data and valid bits.
- The top level holds the array, drain control and output muxing.

Test Plan:
- Reset: hold rst=0 for 2 cycles with ce_i=0 -> sb_count_o=0, sb_empty_o=1, stallreq_o=0, data_o=0.
- Forwarding: write 0x11223344 to 0x100 (sel 1111), then read 0x100 next cycle -> data_o=0x11223344, sb_count_o=1. Then one idle cycle -> count 0; re-read 0x100 -> 0x11223344.
- Byte merge: with 0x100=0x11223344 in the array, write 0x0000AA00 (sel 0010) then 0xBB000000 (sel 1000), then read -> 0xBB22AA44. Write 0x000000CC and 0x000000DD (sel 0001) back-to-back, then read -> low byte 0xDD.
- Full/stall: 4 back-to-back writes to 0x0/0x4/0x8/0xC -> count 4. 5th write to 0x10 -> stallreq_o=1 for one cycle, count goes to 3, then the write enqueues with count 4 and stallreq_o=0. Idle cycles drain to 0; reads return all 5 values.
- Reset mid-operation: buffer 2 writes over known array data, pulse rst=0 for one cycle -> count 0; reads return the original array words.
- DATA_RAM_SB_EN undefined: write 0xCAFEF00D to 0x20, then read the next cycle -> 0xCAFEF00D. stallreq_o stays 0 through 8 back-to-back writes.
